// File: rtl/audio_frame_serializer.sv
// Multi-channel PCM frame serializer: one-deep holding buffer in front of a
// shift register, with self-generated bit clock, word select / frame sync and underrun flag.
module audio_frame_serializer #(
    parameter int DATA_W    = 16,
    parameter int CHANNELS  = 2,
    parameter int BIT_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CHANNELS*DATA_W-1:0]   s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         sclk,
    output logic                         sdata,
    output logic                         lrclk,
    output logic                         underrun,
    output logic                         busy
);

    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam int DIV_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    logic [FRAME_W-1:0] frame_in;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               sclk_q, sclk_d;
    logic               lrclk_q, lrclk_d;
    logic               underrun_q, underrun_d;
    logic               busy_q, busy_d;
    logic               tick, boundary, accept;

    // Channel 0 must sit at whichever end of the shift register is emitted first.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        if (MSB_FIRST != 0) begin : g_msb
            assign frame_in[(CHANNELS-1-k)*DATA_W +: DATA_W] = s_data[k*DATA_W +: DATA_W];
        end else begin : g_lsb
            assign frame_in[k*DATA_W +: DATA_W] = s_data[k*DATA_W +: DATA_W];
        end
    end

    assign s_ready = !hold_full_q && !rst;
    assign accept  = s_valid && s_ready;
    assign tick     = enable && (div_cnt_q == DIV_W'(BIT_DIV - 1));
    assign boundary = tick && (bit_cnt_q == CNT_W'(FRAME_W - 1));

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sclk_d      = sclk_q;
        lrclk_d     = lrclk_q;
        underrun_d  = 1'b0;
        busy_d      = busy_q;

        if (!enable) begin
            div_cnt_d = '0;
            bit_cnt_d = CNT_W'(FRAME_W - 1);
            shreg_d   = '0;
            sclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            busy_d    = 1'b0;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            sclk_d    = (div_cnt_d >= DIV_W'(BIT_DIV / 2));
            if (tick) begin
                bit_cnt_d = boundary ? '0 : bit_cnt_q + CNT_W'(1);
                if (boundary) begin
                    if (hold_full_q) begin
                        shreg_d = hold_q;
                        busy_d  = 1'b1;
                    end else begin
                        shreg_d    = '0;
                        busy_d     = 1'b0;
                        underrun_d = 1'b1;
                    end
                end else if (MSB_FIRST != 0) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[FRAME_W-1:1]};
                end
                if (CHANNELS == 2) begin
                    lrclk_d = (bit_cnt_d >= CNT_W'(DATA_W));
                end else begin
                    lrclk_d = (bit_cnt_d == '0);
                end
            end
        end

        // A boundary only empties hold when it was full, so it never races a handshake.
        if (boundary && hold_full_q) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = frame_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= CNT_W'(FRAME_W - 1);
            sclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_q      <= sclk_d;
            lrclk_q     <= lrclk_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
        end
    end

    assign sclk     = sclk_q;
    assign sdata    = (MSB_FIRST != 0) ? shreg_q[FRAME_W-1] : shreg_q[0];
    assign lrclk    = lrclk_q;
    assign underrun = underrun_q;
    assign busy     = busy_q;

endmodule
